// File: rtl/ay8913_envelope.sv
// AY-3-8913 envelope generator: prescaled period counter driving a 16-step ramp
// with one-shot, hold, repeat and alternate shapes, restarted by a shape write.
module ay8913_envelope #(
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [3:0]             shape,
  output logic [3:0]             envelope,
  output logic                   holding,
  output logic                   cycle_end
);

  localparam int unsigned PresW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

  logic [PresW-1:0]       presc_q, presc_d;
  logic [PERIOD_BITS-1:0] per_q, per_d;
  logic [3:0]             step_q, step_d;
  logic                   flip_q, flip_d;
  logic                   hold_q, hold_d;
  logic [3:0]             held_q, held_d;
  logic [3:0]             shape_q, shape_d;
  logic                   ce_q, ce_d;

  logic [PERIOD_BITS-1:0] per_m1;
  logic                   tick;
  logic                   per_done;
  logic                   step_evt;

  // A zero period behaves as one; >= lets a shortened period fire on the next tick.
  assign per_m1   = (period == '0) ? '0 : period - PERIOD_BITS'(1);
  assign tick     = (presc_q == PresMax);
  assign per_done = (per_q >= per_m1);
  assign step_evt = tick && per_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      per_q   <= '0;
      step_q  <= '0;
      flip_q  <= 1'b0;
      hold_q  <= 1'b1;
      held_q  <= '0;
      shape_q <= '0;
      ce_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      per_q   <= per_d;
      step_q  <= step_d;
      flip_q  <= flip_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      shape_q <= shape_d;
      ce_q    <= ce_d;
    end
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PresW'(1);
    per_d   = per_q;
    step_d  = step_q;
    flip_d  = flip_q;
    hold_d  = hold_q;
    held_d  = held_q;
    shape_d = shape_q;
    ce_d    = 1'b0;

    if (tick) begin
      per_d = per_done ? '0 : per_q + PERIOD_BITS'(1);
    end

    if (step_evt && !hold_q) begin
      if (step_q != 4'hf) begin
        step_d = step_q + 4'd1;
      end else begin
        ce_d = 1'b1;
        if (!shape_q[3]) begin
          hold_d = 1'b1;
          held_d = 4'h0;
        end else if (shape_q[0]) begin
          hold_d = 1'b1;
          held_d = {4{shape_q[2] ^ shape_q[1]}};
        end else begin
          step_d = 4'h0;
          if (shape_q[1]) flip_d = ~flip_q;
        end
      end
    end

    // Restart overrides any coincident tick or step.
    if (restart) begin
      shape_d = shape;
      presc_d = '0;
      per_d   = '0;
      step_d  = '0;
      flip_d  = 1'b0;
      hold_d  = 1'b0;
      ce_d    = 1'b0;
    end
  end

  always_comb begin
    if (hold_q) begin
      envelope = held_q;
    end else if (shape_q[2] ^ flip_q) begin
      envelope = step_q;
    end else begin
      envelope = ~step_q;
    end
  end

  assign holding   = hold_q;
  assign cycle_end = ce_q;

endmodule

// File: tb/tb_ay8913_envelope.sv
// Directed bench for ay8913_envelope: ramp shapes, hold, period changes,
// restart collisions and asynchronous reset, with hand-computed expectations.
module tb_ay8913_envelope;

  logic        clk;
  logic        rst_n;
  logic        restart;
  logic [15:0] period;
  logic [3:0]  shape;
  logic [3:0]  envelope;
  logic        holding;
  logic        cycle_end;

  int checks = 0;
  int errors = 0;

  ay8913_envelope #(
    .PRESCALE    (16),
    .PERIOD_BITS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .period    (period),
    .shape     (shape),
    .envelope  (envelope),
    .holding   (holding),
    .cycle_end (cycle_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; restart is sampled at the next rising edge (edge N).
  // Returns at the negedge after edge N.
  task automatic do_restart(input logic [3:0] s);
    restart = 1'b1;
    shape   = s;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    restart = 1'b0;
    period  = 16'd1;
    shape   = 4'h0;
    #12;
    check("rst_env", 32'(envelope), 32'd0);
    check("rst_hold", 32'(holding), 32'd1);
    check("rst_ce", 32'(cycle_end), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3);
    check("idle_hold", 32'(holding), 32'd1);

    // One-shot decay
    do_restart(4'b0000);
    check("s0_env0", 32'(envelope), 32'd15);
    check("s0_hold0", 32'(holding), 32'd0);
    wait_cyc(15);
    check("s0_env15", 32'(envelope), 32'd15);
    wait_cyc(1);
    check("s0_env16", 32'(envelope), 32'd14);
    wait_cyc(224);
    check("s0_env240", 32'(envelope), 32'd0);
    check("s0_hold240", 32'(holding), 32'd0);
    wait_cyc(15);
    check("s0_ce255", 32'(cycle_end), 32'd0);
    wait_cyc(1);
    check("s0_ce256", 32'(cycle_end), 32'd1);
    check("s0_hold256", 32'(holding), 32'd1);
    check("s0_env256", 32'(envelope), 32'd0);
    wait_cyc(1);
    check("s0_ce257", 32'(cycle_end), 32'd0);
    check("s0_env257", 32'(envelope), 32'd0);

    // Triangle: continue, attack, alternate
    do_restart(4'b1110);
    check("tri_env0", 32'(envelope), 32'd0);
    check("tri_hold0", 32'(holding), 32'd0);
    wait_cyc(240);
    check("tri_env240", 32'(envelope), 32'd15);
    wait_cyc(16);
    check("tri_env256", 32'(envelope), 32'd15);
    check("tri_ce256", 32'(cycle_end), 32'd1);
    wait_cyc(1);
    check("tri_ce257", 32'(cycle_end), 32'd0);
    wait_cyc(15);
    check("tri_env272", 32'(envelope), 32'd14);
    wait_cyc(239);
    check("tri_env511", 32'(envelope), 32'd0);
    check("tri_ce511", 32'(cycle_end), 32'd0);
    wait_cyc(1);
    check("tri_ce512", 32'(cycle_end), 32'd1);
    check("tri_env512", 32'(envelope), 32'd0);
    check("tri_hold512", 32'(holding), 32'd0);
    wait_cyc(16);
    check("tri_env528", 32'(envelope), 32'd1);

    // Decay then hold high
    do_restart(4'b1011);
    check("dh_env0", 32'(envelope), 32'd15);
    wait_cyc(240);
    check("dh_env240", 32'(envelope), 32'd0);
    wait_cyc(16);
    check("dh_hold256", 32'(holding), 32'd1);
    check("dh_env256", 32'(envelope), 32'd15);
    wait_cyc(100);
    check("dh_env356", 32'(envelope), 32'd15);

    // Attack then hold high; restart while holding resumes at once
    do_restart(4'b1101);
    check("ah_hold0", 32'(holding), 32'd0);
    check("ah_env0", 32'(envelope), 32'd0);
    wait_cyc(240);
    check("ah_env240", 32'(envelope), 32'd15);
    wait_cyc(16);
    check("ah_hold256", 32'(holding), 32'd1);
    check("ah_env256", 32'(envelope), 32'd15);

    // Sawtooth up, period 3 and period 0
    period = 16'd3;
    do_restart(4'b1100);
    wait_cyc(47);
    check("p3_env47", 32'(envelope), 32'd0);
    wait_cyc(1);
    check("p3_env48", 32'(envelope), 32'd1);
    wait_cyc(48);
    check("p3_env96", 32'(envelope), 32'd2);
    period = 16'd0;
    do_restart(4'b1100);
    wait_cyc(15);
    check("p0_env15", 32'(envelope), 32'd0);
    wait_cyc(1);
    check("p0_env16", 32'(envelope), 32'd1);

    // Period shortened from 100 to 2 with the count at 50
    period = 16'd100;
    do_restart(4'b1100);
    wait_cyc(805);
    check("pc_env805", 32'(envelope), 32'd0);
    period = 16'd2;
    wait_cyc(10);
    check("pc_env815", 32'(envelope), 32'd0);
    wait_cyc(1);
    check("pc_env816", 32'(envelope), 32'd1);

    // Restart coinciding with the step event that would leave step 7
    period = 16'd1;
    do_restart(4'b1100);
    wait_cyc(127);
    check("rc_env127", 32'(envelope), 32'd7);
    do_restart(4'b0000);
    check("rc_env", 32'(envelope), 32'd15);
    check("rc_ce", 32'(cycle_end), 32'd0);
    check("rc_hold", 32'(holding), 32'd0);
    wait_cyc(16);
    check("rc_env16", 32'(envelope), 32'd14);

    // Asynchronous reset mid-ramp, between clock edges
    do_restart(4'b1100);
    wait_cyc(100);
    check("ar_env_pre", 32'(envelope), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("ar_env", 32'(envelope), 32'd0);
    check("ar_hold", 32'(holding), 32'd1);
    check("ar_ce", 32'(cycle_end), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(40);
    check("ar_silent", 32'(envelope), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
